epp_slave_ctrl: RTL and testbench
=================================

# epp_slave_ctrl

EPP (IEEE 1284 Enhanced Parallel Port) slave handshake controller that sits between the host parallel-port pins and the BRAM communication controller. It synchronises the asynchronous host strobes, runs the address/data read/write handshake with the host, holds the EPP address register, and produces the write data, `stb_data` strobe and `ctrl_wr` qualifier that the downstream BRAM controller consumes. It also returns the downstream read data to the host.

## Interface
- `SYNC_STAGES`, 2: flip-flop stages on `astb_n`, `dstb_n` and `pwr`; minimum 2.
- `RD_LAT`, 2: cycles from `stb_data` falling to `rd_data` capture on a data read; minimum 1.
- `TIMEOUT`, 1024: cycles allowed in HOLD before forced release.
- `clk` in 1: the single system clock.
- `rst_n` in 1: synchronous, active-low reset.
- `astb_n` in 1: host address strobe, asynchronous, active low.
- `dstb_n` in 1: host data strobe, asynchronous, active low.
- `pwr` in 1: host write flag, asynchronous; 0 = write, 1 = read.
- `pdb_in` in 8: host data bus, input side.
- `pdb_out` out 8: host data bus, output side.
- `pdb_oe` out 1: drive enable for `pdb_out`; the top level builds the tristate.
- `pwait` out 1: EPP wait/acknowledge to the host.
- `addr_reg` out 8: EPP address register, routed to the downstream address input.
- `wr_data` out 8: data latched from the host, routed to the downstream data input.
- `rd_data` in 8: read data from the downstream controller.
- `stb_data` out 1: downstream data strobe; idle high. The falling edge clocks the BRAM and the rising edge advances the downstream address.
- `ctrl_wr` out 1: downstream write qualifier; 0 = write, idle 1.
- `err` out 1: single-cycle pulse on a protocol error or timeout.

## Operation
- **Reset values**, applied while `rst_n`=0 at a clock edge, including mid-transfer:
  - `pdb_out`=0, `pdb_oe`=0, `pwait`=0.
  - `addr_reg`=0, `wr_data`=0.
  - `stb_data`=1, `ctrl_wr`=1, `err`=0.
  - FSM returns to IDLE, synchronisers preset to 1, timeout counter cleared.
- **Synchronised signals:** `astb_s`, `dstb_s` and `pwr_s` are the synchronised versions of the host inputs. `pdb_in` is sampled raw, because the host holds it stable throughout the strobe.
- **FSM states:** IDLE, A_WR, A_RD, D_WR, D_RD, HOLD, REL.
- **IDLE:**
  - `astb_s`=0, `dstb_s`=1 → A_WR if `pwr_s`=0, otherwise A_RD.
  - `dstb_s`=0, `astb_s`=1 → D_WR if `pwr_s`=0, otherwise D_RD.
  - Both strobes low → pulse `err`, stay in IDLE, no side effects.
- **A_WR:** `addr_reg`←`pdb_in`, → HOLD.
- **A_RD:** `pdb_out`←`addr_reg`, `pdb_oe`←1, → HOLD.
- **D_WR:**
  - `wr_data`←`pdb_in` and `ctrl_wr`←0 in the entry cycle.
  - Next cycle `stb_data`←0, → HOLD.
- **D_RD:**
  - `ctrl_wr` stays 1 and `stb_data`←0 on entry.
  - After `RD_LAT` cycles: `pdb_out`←`rd_data`, `pdb_oe`←1, → HOLD.
- **HOLD:**
  - `pwait`←1 on entry.
  - Wait for the strobe that opened the transfer to read high (synchronised); then `pwait`←0, `pdb_oe`←0, `stb_data`←1, → REL.
  - Strobe polarity changes to the other strobe during HOLD are ignored.
- **REL:** `ctrl_wr`←1, → IDLE.
  - `ctrl_wr` therefore stays 0 across the rising edge of `stb_data`, which the downstream controller requires.
- **Timeout:**
  - The counter runs while in HOLD.
  - On reaching `TIMEOUT`-1: force the HOLD exit actions, pulse `err`, → REL.
  - The FSM then stays in IDLE until both synchronised strobes read high, which prevents re-triggering on a stuck strobe.
- **Held values:** `addr_reg` and `wr_data` hold their values until overwritten. No auto-increment happens here; address stepping belongs downstream.

## Timing
- Cycle 0 is the first IDLE cycle that sees a synchronised strobe low. Host strobe to cycle 0 is `SYNC_STAGES` clocks, plus up to one more.
- **Address write:**
  - `addr_reg` updates at cycle 1.
  - `pwait` rises at cycle 2.
- **Address read:**
  - `pdb_oe` and `pdb_out` are valid at cycle 1.
  - `pwait` rises at cycle 2, so data is set up one cycle before the acknowledge.
- **Data write:**
  - `wr_data` and `ctrl_wr`=0 at cycle 1.
  - `stb_data` falls at cycle 2; `pwait` rises at cycle 3.
- **Data read:**
  - `stb_data` falls at cycle 1.
  - `pdb_out` and `pdb_oe` are valid at cycle 1+`RD_LAT`.
  - `pwait` rises at cycle 2+`RD_LAT`.
- **Release:** let R be the first cycle HOLD sees the strobe high.
  - `pwait`, `pdb_oe` and `stb_data` transition at R+1.
  - `ctrl_wr` returns to 1 at R+2.
  - IDLE is re-entered at R+2, so at least one IDLE cycle separates transfers.
- **`stb_data` low width:** never less than 1 cycle; on a write it covers the entire HOLD interval.
- **`err`:** exactly one cycle high, registered.

## Test plan
- **Reset:** apply `rst_n`=0 during D_WR HOLD with `stb_data`=0 → the next cycle shows `stb_data`=1, `ctrl_wr`=1, `pwait`=0, `pdb_oe`=0 and IDLE.
- **Address write then read:**
  - `astb_n` low, `pwr`=0, `pdb_in`=0x40 → `addr_reg`=0x40, `pwait` high until the strobe is released.
  - Then an address read → `pdb_out`=0x40, with `pdb_oe` high before `pwait`.
- **Data write:** `dstb_n` low, `pwr`=0, `pdb_in`=0xA5 → `wr_data`=0xA5 and `ctrl_wr`=0 before `stb_data` falls; `ctrl_wr` is still 0 at the `stb_data` rising edge.
- **Data read:** `rd_data`=0x3C presented after `stb_data` falls, with `RD_LAT`=2 → `pdb_out`=0x3C exactly 3 cycles after cycle 0, and `pwait` one cycle later.
- **Protocol error:** both strobes low simultaneously → `err` is a 1-cycle pulse, and `addr_reg`, `wr_data`, `stb_data` and `pwait` are unchanged.
- **Timeout:** with `TIMEOUT`=16, hold `dstb_n` low indefinitely → `err` pulses 16 cycles after HOLD entry and `pwait` drops. No new transfer starts until `dstb_n` goes high and low again.

Source files
------------

// File: rtl/epp_slave_ctrl.sv
// -----------------------------------------------------------------------------
// epp_slave_ctrl
//
// EPP (IEEE 1284) slave handshake controller. Synchronises the asynchronous
// host strobes, runs the address/data read/write handshake with the host,
// holds the EPP address register and drives the data strobe / write qualifier
// consumed by the downstream BRAM communication controller.
//
// Ports
//   clk, rst_n        system clock, synchronous active-low reset
//   astb_n, dstb_n    host address / data strobes (async, active low)
//   pwr               host write flag (async): 0 = write, 1 = read
//   pdb_in            host data bus, input side (sampled raw)
//   pdb_out, pdb_oe   host data bus, output side and its drive enable
//   pwait             EPP wait / acknowledge to the host
//   addr_reg          EPP address register (to downstream address input)
//   wr_data           data latched from the host (to downstream data input)
//   rd_data           read data returned by the downstream controller
//   stb_data          downstream data strobe, idle high
//   ctrl_wr           downstream write qualifier, 0 = write, idle high
//   err               one-cycle pulse on protocol error or HOLD timeout
// -----------------------------------------------------------------------------
module epp_slave_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int RD_LAT      = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       astb_n,
    input  logic       dstb_n,
    input  logic       pwr,
    input  logic [7:0] pdb_in,
    output logic [7:0] pdb_out,
    output logic       pdb_oe,
    output logic       pwait,
    output logic [7:0] addr_reg,
    output logic [7:0] wr_data,
    input  logic [7:0] rd_data,
    output logic       stb_data,
    output logic       ctrl_wr,
    output logic       err
);

    // Parameters are clamped to their legal minimums.
    localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int RL = (RD_LAT < 1) ? 1 : RD_LAT;
    localparam int TO = (TIMEOUT < 2) ? 2 : TIMEOUT;
    localparam int LW = $clog2(RL + 2);
    localparam int TW = $clog2(TO);

    localparam logic [LW-1:0] LAT_CAP  = LW'(RL - 1);
    localparam logic [LW-1:0] LAT_DONE = LW'(RL);
    localparam logic [TW-1:0] TMO_LAST = TW'(TO - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_A_WR = 3'd1;
    localparam logic [2:0] S_A_RD = 3'd2;
    localparam logic [2:0] S_D_WR = 3'd3;
    localparam logic [2:0] S_D_RD = 3'd4;
    localparam logic [2:0] S_HOLD = 3'd5;
    localparam logic [2:0] S_REL  = 3'd6;

    // Synchronisers
    logic [SS-1:0] astb_sync_q;
    logic [SS-1:0] dstb_sync_q;
    logic [SS-1:0] pwr_sync_q;
    logic          astb_s;
    logic          dstb_s;
    logic          pwr_s;

    assign astb_s = astb_sync_q[SS-1];
    assign dstb_s = dstb_sync_q[SS-1];
    assign pwr_s  = pwr_sync_q[SS-1];

    // FSM and datapath state
    logic [2:0]    state_q,    state_d;
    logic [LW-1:0] lat_q,      lat_d;
    logic [TW-1:0] tmo_q,      tmo_d;
    logic          is_addr_q,  is_addr_d;
    logic          lock_q,     lock_d;
    logic [7:0]    pdb_out_q,  pdb_out_d;
    logic          pdb_oe_q,   pdb_oe_d;
    logic          pwait_q,    pwait_d;
    logic [7:0]    addr_q,     addr_d;
    logic [7:0]    wr_data_q,  wr_data_d;
    logic          stb_q,      stb_d;
    logic          ctrl_wr_q,  ctrl_wr_d;
    logic          err_q,      err_d;

    // Strobe that opened the current transfer, read back as released (high).
    logic          open_stb_hi;
    assign open_stb_hi = is_addr_q ? astb_s : dstb_s;

    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        tmo_d     = tmo_q;
        is_addr_d = is_addr_q;
        lock_d    = lock_q;
        pdb_out_d = pdb_out_q;
        pdb_oe_d  = pdb_oe_q;
        pwait_d   = pwait_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        stb_d     = stb_q;
        ctrl_wr_d = ctrl_wr_q;
        err_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                lat_d = '0;
                tmo_d = '0;
                if (lock_q) begin
                    // After a timeout or a double-strobe error, wait for the
                    // host to release everything so a stuck strobe cannot
                    // re-trigger a transfer or repeat the error pulse.
                    if (astb_s && dstb_s) begin
                        lock_d = 1'b0;
                    end
                end else if (!astb_s && !dstb_s) begin
                    err_d  = 1'b1;
                    lock_d = 1'b1;
                end else if (!astb_s) begin
                    is_addr_d = 1'b1;
                    if (!pwr_s) begin
                        addr_d  = pdb_in;
                        state_d = S_A_WR;
                    end else begin
                        pdb_out_d = addr_q;
                        pdb_oe_d  = 1'b1;
                        state_d   = S_A_RD;
                    end
                end else if (!dstb_s) begin
                    is_addr_d = 1'b0;
                    if (!pwr_s) begin
                        wr_data_d = pdb_in;
                        ctrl_wr_d = 1'b0;
                        state_d   = S_D_WR;
                    end else begin
                        stb_d   = 1'b0;
                        state_d = S_D_RD;
                    end
                end
            end

            S_A_WR, S_A_RD: begin
                pwait_d = 1'b1;
                state_d = S_HOLD;
            end

            S_D_WR: begin
                // ctrl_wr and wr_data are set up one cycle before the strobe
                // falls, so the BRAM sees stable data at its clock edge.
                if (lat_q == '0) begin
                    stb_d = 1'b0;
                    lat_d = LW'(1);
                end else begin
                    pwait_d = 1'b1;
                    state_d = S_HOLD;
                end
            end

            S_D_RD: begin
                lat_d = lat_q + LW'(1);
                if (lat_q == LAT_CAP) begin
                    pdb_out_d = rd_data;
                    pdb_oe_d  = 1'b1;
                end
                // One extra cycle so the data is set up before the acknowledge.
                if (lat_q == LAT_DONE) begin
                    pwait_d = 1'b1;
                    state_d = S_HOLD;
                end
            end

            S_HOLD: begin
                tmo_d = tmo_q + TW'(1);
                if (open_stb_hi || (tmo_q == TMO_LAST)) begin
                    pwait_d  = 1'b0;
                    pdb_oe_d = 1'b0;
                    stb_d    = 1'b1;
                    tmo_d    = '0;
                    state_d  = S_REL;
                    if (!open_stb_hi) begin
                        err_d  = 1'b1;
                        lock_d = 1'b1;
                    end
                end
            end

            S_REL: begin
                // ctrl_wr returns high one cycle after stb_data rises so the
                // downstream controller sees a qualified rising edge.
                ctrl_wr_d = 1'b1;
                state_d   = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            astb_sync_q <= '1;
            dstb_sync_q <= '1;
            pwr_sync_q  <= '1;
            state_q     <= S_IDLE;
            lat_q       <= '0;
            tmo_q       <= '0;
            is_addr_q   <= 1'b0;
            lock_q      <= 1'b0;
            pdb_out_q   <= 8'h00;
            pdb_oe_q    <= 1'b0;
            pwait_q     <= 1'b0;
            addr_q      <= 8'h00;
            wr_data_q   <= 8'h00;
            stb_q       <= 1'b1;
            ctrl_wr_q   <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            astb_sync_q <= {astb_sync_q[SS-2:0], astb_n};
            dstb_sync_q <= {dstb_sync_q[SS-2:0], dstb_n};
            pwr_sync_q  <= {pwr_sync_q[SS-2:0], pwr};
            state_q     <= state_d;
            lat_q       <= lat_d;
            tmo_q       <= tmo_d;
            is_addr_q   <= is_addr_d;
            lock_q      <= lock_d;
            pdb_out_q   <= pdb_out_d;
            pdb_oe_q    <= pdb_oe_d;
            pwait_q     <= pwait_d;
            addr_q      <= addr_d;
            wr_data_q   <= wr_data_d;
            stb_q       <= stb_d;
            ctrl_wr_q   <= ctrl_wr_d;
            err_q       <= err_d;
        end
    end

    assign pdb_out  = pdb_out_q;
    assign pdb_oe   = pdb_oe_q;
    assign pwait    = pwait_q;
    assign addr_reg = addr_q;
    assign wr_data  = wr_data_q;
    assign stb_data = stb_q;
    assign ctrl_wr  = ctrl_wr_q;
    assign err      = err_q;

endmodule

// File: tb/tb_epp_slave_ctrl.sv
// -----------------------------------------------------------------------------
// tb_epp_slave_ctrl
//
// Testbench for epp_slave_ctrl: directed handshake scenarios plus randomized
// host transfers checked against a transaction-level model of the EPP
// registers (address register, write data, read return).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_epp_slave_ctrl;

    localparam int SS = 2;
    localparam int RL = 2;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       astb_n;
    logic       dstb_n;
    logic       pwr;
    logic [7:0] pdb_in;
    logic [7:0] pdb_out;
    logic       pdb_oe;
    logic       pwait;
    logic [7:0] addr_reg;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       stb_data;
    logic       ctrl_wr;
    logic       err;

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;

    // Transaction-level model of the slave's visible registers.
    logic [7:0] model_addr;
    logic [7:0] model_wr;

    always #5 clk = ~clk;

    epp_slave_ctrl #(
        .SYNC_STAGES(SS),
        .RD_LAT     (RL),
        .TIMEOUT    (TO)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .astb_n  (astb_n),
        .dstb_n  (dstb_n),
        .pwr     (pwr),
        .pdb_in  (pdb_in),
        .pdb_out (pdb_out),
        .pdb_oe  (pdb_oe),
        .pwait   (pwait),
        .addr_reg(addr_reg),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .stb_data(stb_data),
        .ctrl_wr (ctrl_wr),
        .err     (err)
    );

    always @(posedge clk) begin
        if (err === 1'b1) err_pulses <= err_pulses + 1;
    end

    function automatic logic sig(input int sel);
        case (sel)
            0:       return pwait;
            1:       return stb_data;
            2:       return ctrl_wr;
            3:       return pdb_oe;
            default: return err;
        endcase
    endfunction

    // Steps negedges until the selected output equals val; n = -1 on expiry.
    task automatic wait_sig(input int sel, input logic val, input int maxc, output int n);
        n = 0;
        while (sig(sel) !== val && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (sig(sel) !== val) n = -1;
    endtask

    // Drives one complete host transfer and reports what the host saw on the
    // bus while pwait was high.
    task automatic host_xfer(input bit is_addr, input bit is_read, input logic [7:0] d,
                             input int hold, output logic [7:0] got, output logic got_oe,
                             output bit ok);
        int n;
        pwr    = is_read;
        pdb_in = d;
        if (is_addr) astb_n = 1'b0;
        else         dstb_n = 1'b0;
        wait_sig(0, 1'b1, 30, n);
        ok     = (n >= 0);
        got    = pdb_out;
        got_oe = pdb_oe;
        repeat (hold) @(negedge clk);
        astb_n = 1'b1;
        dstb_n = 1'b1;
        wait_sig(0, 1'b0, 10, n);
        if (n < 0) ok = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        astb_n  = 1'b1;
        dstb_n  = 1'b1;
        pwr     = 1'b1;
        pdb_in  = 8'h00;
        rd_data = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({pdb_out, pdb_oe, pwait} !== {8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_host_side: got pdb_out=%h oe=%b pwait=%b, expected 00 0 0",
                     pdb_out, pdb_oe, pwait);
        end
        checks++;
        if ({addr_reg, wr_data, stb_data, ctrl_wr, err} !== {8'h00, 8'h00, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_downstream: got addr=%h wr=%h stb=%b ctrl_wr=%b err=%b, expected 00 00 1 1 0",
                     addr_reg, wr_data, stb_data, ctrl_wr, err);
        end
        rst_n = 1'b1;
        model_addr = 8'h00;
        model_wr   = 8'h00;
        repeat (4) @(negedge clk);
        checks++;
        if (pwait !== 1'b0 || stb_data !== 1'b1) begin
            errors++;
            $display("FAIL idle_after_reset: got pwait=%b stb=%b, expected 0 1", pwait, stb_data);
        end
    endtask

    task automatic test_addr_write_read;
        int n;
        pwr    = 1'b0;
        pdb_in = 8'h40;
        astb_n = 1'b0;
        n = 0;
        while (addr_reg !== 8'h40 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != SS + 1) begin
            errors++;
            $display("FAIL addr_wr_latency: got %0d cycles, expected %0d", n, SS + 1);
        end
        model_addr = 8'h40;
        @(negedge clk);
        checks++;
        if (pwait !== 1'b1) begin
            errors++;
            $display("FAIL addr_wr_pwait: got %b, expected 1", pwait);
        end
        repeat (5) @(negedge clk);
        pdb_in = 8'h99;
        checks++;
        if (pwait !== 1'b1) begin
            errors++;
            $display("FAIL addr_wr_pwait_held: got %b, expected 1", pwait);
        end
        astb_n = 1'b1;
        wait_sig(0, 1'b0, 10, n);
        checks++;
        if (n != SS + 1 || addr_reg !== model_addr) begin
            errors++;
            $display("FAIL addr_wr_release: got %0d cycles addr=%h, expected %0d cycles addr=%h",
                     n, addr_reg, SS + 1, model_addr);
        end
        repeat (2) @(negedge clk);

        pwr    = 1'b1;
        astb_n = 1'b0;
        wait_sig(3, 1'b1, 10, n);
        checks++;
        if (n != SS + 1 || pdb_out !== model_addr || pwait !== 1'b0) begin
            errors++;
            $display("FAIL addr_rd_setup: got %0d cycles pdb_out=%h pwait=%b, expected %0d %h 0",
                     n, pdb_out, pwait, SS + 1, model_addr);
        end
        @(negedge clk);
        checks++;
        if (pwait !== 1'b1 || pdb_oe !== 1'b1) begin
            errors++;
            $display("FAIL addr_rd_ack: got pwait=%b oe=%b, expected 1 1", pwait, pdb_oe);
        end
        astb_n = 1'b1;
        wait_sig(0, 1'b0, 10, n);
        checks++;
        if (n < 0 || pdb_oe !== 1'b0) begin
            errors++;
            $display("FAIL addr_rd_release: got n=%0d oe=%b, expected oe 0 with pwait drop", n, pdb_oe);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_data_write;
        int n;
        pwr    = 1'b0;
        pdb_in = 8'hA5;
        dstb_n = 1'b0;
        wait_sig(2, 1'b0, 10, n);
        checks++;
        if (n != SS + 1 || wr_data !== 8'hA5 || stb_data !== 1'b1) begin
            errors++;
            $display("FAIL dwr_setup: got %0d cycles wr=%h stb=%b, expected %0d A5 1",
                     n, wr_data, stb_data, SS + 1);
        end
        model_wr = 8'hA5;
        @(negedge clk);
        checks++;
        if (stb_data !== 1'b0 || pwait !== 1'b0) begin
            errors++;
            $display("FAIL dwr_stb_fall: got stb=%b pwait=%b, expected 0 0", stb_data, pwait);
        end
        @(negedge clk);
        checks++;
        if (pwait !== 1'b1) begin
            errors++;
            $display("FAIL dwr_pwait: got %b, expected 1", pwait);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (stb_data !== 1'b0 || ctrl_wr !== 1'b0) begin
            errors++;
            $display("FAIL dwr_hold: got stb=%b ctrl_wr=%b, expected 0 0", stb_data, ctrl_wr);
        end
        dstb_n = 1'b1;
        pdb_in = 8'h00;
        wait_sig(1, 1'b1, 10, n);
        checks++;
        if (n != SS + 1 || ctrl_wr !== 1'b0 || pwait !== 1'b0) begin
            errors++;
            $display("FAIL dwr_stb_rise: got %0d cycles ctrl_wr=%b pwait=%b, expected %0d 0 0",
                     n, ctrl_wr, pwait, SS + 1);
        end
        @(negedge clk);
        checks++;
        if (ctrl_wr !== 1'b1 || wr_data !== model_wr) begin
            errors++;
            $display("FAIL dwr_ctrl_rise: got ctrl_wr=%b wr=%h, expected 1 %h", ctrl_wr, wr_data, model_wr);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_data_read;
        int n;
        rd_data = 8'h00;
        pwr     = 1'b1;
        dstb_n  = 1'b0;
        wait_sig(1, 1'b0, 10, n);
        checks++;
        if (n != SS + 1 || ctrl_wr !== 1'b1 || pdb_oe !== 1'b0) begin
            errors++;
            $display("FAIL drd_stb_fall: got %0d cycles ctrl_wr=%b oe=%b, expected %0d 1 0",
                     n, ctrl_wr, pdb_oe, SS + 1);
        end
        rd_data = 8'h3C;
        repeat (RL - 1) @(negedge clk);
        checks++;
        if (pdb_oe !== 1'b0) begin
            errors++;
            $display("FAIL drd_early_oe: got oe=%b, expected 0", pdb_oe);
        end
        @(negedge clk);
        checks++;
        if (pdb_oe !== 1'b1 || pdb_out !== 8'h3C || pwait !== 1'b0) begin
            errors++;
            $display("FAIL drd_data: got oe=%b pdb_out=%h pwait=%b, expected 1 3C 0",
                     pdb_oe, pdb_out, pwait);
        end
        rd_data = 8'hFF;
        @(negedge clk);
        checks++;
        if (pwait !== 1'b1 || pdb_out !== 8'h3C) begin
            errors++;
            $display("FAIL drd_ack: got pwait=%b pdb_out=%h, expected 1 3C", pwait, pdb_out);
        end
        repeat (2) @(negedge clk);
        dstb_n = 1'b1;
        wait_sig(0, 1'b0, 10, n);
        checks++;
        if (n < 0 || pdb_oe !== 1'b0 || stb_data !== 1'b1) begin
            errors++;
            $display("FAIL drd_release: got n=%0d oe=%b stb=%b, expected oe 0 stb 1", n, pdb_oe, stb_data);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_protocol_error;
        logic [7:0] a;
        logic [7:0] w;
        logic [7:0] got;
        logic       got_oe;
        bit         ok;
        int         hi;
        bit         bad;
        a      = addr_reg;
        w      = wr_data;
        hi     = 0;
        bad    = 1'b0;
        pwr    = 1'b0;
        pdb_in = 8'h77;
        astb_n = 1'b0;
        dstb_n = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (err === 1'b1) hi++;
            if (addr_reg !== a || wr_data !== w || stb_data !== 1'b1 || pwait !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (hi != 1) begin
            errors++;
            $display("FAIL proto_err_pulse: got %0d cycles high, expected 1", hi);
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL proto_err_side_effect: got addr=%h wr=%h stb=%b pwait=%b, expected %h %h 1 0",
                     addr_reg, wr_data, stb_data, pwait, a, w);
        end
        astb_n = 1'b1;
        dstb_n = 1'b1;
        repeat (4) @(negedge clk);
        host_xfer(1'b1, 1'b0, 8'h5A, 1, got, got_oe, ok);
        model_addr = 8'h5A;
        checks++;
        if (!ok || addr_reg !== model_addr) begin
            errors++;
            $display("FAIL proto_err_recover: got ok=%0d addr=%h, expected 1 %h", ok, addr_reg, model_addr);
        end
    endtask

    task automatic test_timeout;
        int n;
        bit bad;
        pwr    = 1'b0;
        pdb_in = 8'h11;
        dstb_n = 1'b0;
        wait_sig(0, 1'b1, 20, n);
        model_wr = 8'h11;
        n = 0;
        while (err !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != TO) begin
            errors++;
            $display("FAIL timeout_latency: got %0d cycles, expected %0d", n, TO);
        end
        checks++;
        if (pwait !== 1'b0 || stb_data !== 1'b1) begin
            errors++;
            $display("FAIL timeout_release: got pwait=%b stb=%b, expected 0 1", pwait, stb_data);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err_width: got err=%b, expected 0", err);
        end
        bad = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (pwait !== 1'b0 || stb_data !== 1'b1 || ctrl_wr !== 1'b1 || err !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL timeout_stuck_lockout: got pwait=%b stb=%b ctrl_wr=%b, expected 0 1 1",
                     pwait, stb_data, ctrl_wr);
        end
        dstb_n = 1'b1;
        repeat (4) @(negedge clk);
        pwr    = 1'b1;
        dstb_n = 1'b0;
        wait_sig(1, 1'b0, 10, n);
        checks++;
        if (n != SS + 1) begin
            errors++;
            $display("FAIL timeout_restart: got %0d cycles, expected %0d", n, SS + 1);
        end
        wait_sig(0, 1'b1, 20, n);
        dstb_n = 1'b1;
        wait_sig(0, 1'b0, 10, n);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int n;
        pwr    = 1'b0;
        pdb_in = 8'hC3;
        dstb_n = 1'b0;
        wait_sig(0, 1'b1, 20, n);
        checks++;
        if (n < 0 || stb_data !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_setup: got n=%0d stb=%b, expected HOLD with stb 0", n, stb_data);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({stb_data, ctrl_wr, pwait, pdb_oe, wr_data} !== {1'b1, 1'b1, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL rst_mid_values: got stb=%b ctrl_wr=%b pwait=%b oe=%b wr=%h, expected 1 1 0 0 00",
                     stb_data, ctrl_wr, pwait, pdb_oe, wr_data);
        end
        dstb_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        model_addr = 8'h00;
        model_wr   = 8'h00;
        repeat (4) @(negedge clk);
        checks++;
        if (pwait !== 1'b0 || stb_data !== 1'b1 || addr_reg !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_idle: got pwait=%b stb=%b addr=%h, expected 0 1 00",
                     pwait, stb_data, addr_reg);
        end
    endtask

    task automatic test_random;
        int         op;
        int         hold;
        int         e0;
        logic [7:0] d;
        logic [7:0] r;
        logic [7:0] got;
        logic       got_oe;
        bit         ok;
        for (int i = 0; i < 40; i++) begin
            op      = int'($urandom_range(0, 3));
            hold    = int'($urandom_range(0, 6));
            d       = 8'($urandom);
            r       = 8'($urandom);
            rd_data = r;
            e0      = err_pulses;
            host_xfer(op[1], op[0], d, hold, got, got_oe, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL rand_handshake[%0d]: op=%0d no pwait handshake", i, op);
            end
            checks++;
            case (op)
                2: begin
                    model_addr = d;
                    if (addr_reg !== model_addr) begin
                        errors++;
                        $display("FAIL rand_addr_wr[%0d]: got %h, expected %h", i, addr_reg, model_addr);
                    end
                end
                3: begin
                    if (got !== model_addr || got_oe !== 1'b1) begin
                        errors++;
                        $display("FAIL rand_addr_rd[%0d]: got %h oe=%b, expected %h oe=1", i, got, got_oe, model_addr);
                    end
                end
                0: begin
                    model_wr = d;
                    if (wr_data !== model_wr || ctrl_wr !== 1'b1) begin
                        errors++;
                        $display("FAIL rand_data_wr[%0d]: got %h ctrl_wr=%b, expected %h 1", i, wr_data, ctrl_wr, model_wr);
                    end
                end
                default: begin
                    if (got !== r || got_oe !== 1'b1) begin
                        errors++;
                        $display("FAIL rand_data_rd[%0d]: got %h oe=%b, expected %h oe=1", i, got, got_oe, r);
                    end
                end
            endcase
            checks++;
            if (err_pulses != e0) begin
                errors++;
                $display("FAIL rand_no_err[%0d]: got %0d err pulses, expected 0", i, err_pulses - e0);
            end
        end
        checks++;
        if (addr_reg !== model_addr || wr_data !== model_wr) begin
            errors++;
            $display("FAIL rand_final_regs: got addr=%h wr=%h, expected %h %h",
                     addr_reg, wr_data, model_addr, model_wr);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_addr_write_read();
        test_data_write();
        test_data_read();
        test_protocol_error();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
